pipe_stage_fifo: RTL and testbench
==================================

Name: pipe_stage_fifo

Overview:
- Parametrised successor to the single-register valid/rdy stage link used between Fetch, Decode, Execute, Mem and WB.
- Inserted on any F2D, D2E, E2M or M2W boundary, the link becomes a DEPTH-entry elastic buffer instead of one register.
- Adds pipeline flush for branch/trap redirect, occupancy and almost-full outputs, and a saturating back-pressure (stall) counter for performance events.
- Slave side faces the upstream stage master; master side faces the downstream stage slave.

Parameters:
- DATA_W, 32: width of the stage payload (set to $bits of FET_2_DEC, DEC_2_EXE, etc.).
- DEPTH, 2: number of entries, 1..16; need not be a power of two.
- AF_MARGIN, 1: almost_full asserts when count >= DEPTH-AF_MARGIN; range 0..DEPTH-1.
- STALL_W, 16: width of the stall counter.

Ports:
- clk_in  input  1  core clock; all state updates on rising edge.
- reset_n_in  input  1  asynchronous, active-low reset.
- s_valid  input  1  upstream has payload.
- s_data  input  DATA_W  upstream payload.
- s_rdy  output  1  buffer can accept this cycle.
- m_valid  output  1  head entry is valid.
- m_data  output  DATA_W  head entry payload.
- m_rdy  input  1  downstream takes the head this cycle.
- flush  input  1  synchronous discard of all contents.
- count  output  $clog2(DEPTH+1)  current occupancy.
- almost_full  output  1  count >= DEPTH-AF_MARGIN.
- stall_cnt  output  STALL_W  saturating count of cycles with s_valid && !s_rdy.
- stall_clr  input  1  synchronous clear of stall_cnt.

Behaviour:
- Reset (reset_n_in=0, asynchronous):
  - count=0; write and read pointers=0.
  - s_rdy=1 (DEPTH>=1), m_valid=0, almost_full=(DEPTH-AF_MARGIN==0), stall_cnt=0.
  - Storage contents are don't-care; m_data is don't-care while m_valid=0.
- Reset release: operation begins on the first rising edge after deassertion. Reset asserted mid-transfer discards all contents immediately.
- Handshake:
  - Push = s_valid && s_rdy. Pop = m_valid && m_rdy.
  - Once s_valid is asserted, upstream holds s_valid and s_data until s_rdy is seen.
  - m_data is stable while m_valid && !m_rdy.
- Readiness:
  - s_rdy = (count != DEPTH) || m_rdy. A full buffer accepts a push in the same cycle as a pop.
  - This is the only combinational m_rdy->s_rdy path. Bench checks the path is loop-free at integration.
- Outputs:
  - m_valid = (count != 0). m_data = storage[rd_ptr], driven directly from storage with no extra register.
  - Latency: a payload pushed at edge N appears on m_valid/m_data after edge N. There is no same-cycle bypass into an empty buffer.
- Pointers:
  - wr_ptr increments on push, rd_ptr on pop.
  - Each wraps from DEPTH-1 to 0 by explicit compare, not modulo 2^n.
- Count update (no flush):
  - push only: +1.
  - pop only: -1.
  - push and pop together: unchanged. Both pointers advance; valid at count=0? No. At count=0 pop is impossible, so only push applies.
- Flush:
  - Has priority over push and pop in the same cycle. Next cycle: count=0, wr_ptr=rd_ptr=0, m_valid=0.
  - s_rdy is unaffected by flush in the flush cycle, so upstream may see a handshake whose data is dropped. Upstream stages must kill their own valid on flush.
  - Flush with count=0 is a no-op.
- almost_full is registered-equivalent, decoded from count with no combinational input dependence.
- stall_cnt:
  - Increments when s_valid && !s_rdy && !flush.
  - Saturates at 2^STALL_W-1.
  - stall_clr takes priority over increment; the next value is 0.
  - Not cleared by flush.
- Illegal parameters: DEPTH<1 or AF_MARGIN>=DEPTH are rejected by an elaboration-time assertion.
- Assertions:
  - count never exceeds DEPTH.
  - No pop when count=0.
  - s_data is stable while s_valid && !s_rdy.

Test Plan (DATA_W=8, DEPTH=4, AF_MARGIN=1 unless noted):
- Fill and drain:
  - Stimulus: push 0x11,0x22,0x33,0x44 on consecutive cycles with m_rdy=0.
  - Response: count 1,2,3,4; almost_full asserts at count=3; s_rdy=0 at count=4; stall_cnt=1 after one extra cycle of s_valid.
  - Then m_rdy=1: outputs 0x11..0x44 in order, one per cycle, and count returns to 0.
- Full push/pop:
  - Stimulus: at count=4, s_valid=1 with 0x55 and m_rdy=1.
  - Response: s_rdy=1, 0x11 popped, count stays 4, and 0x55 emerges fifth in order.
- Flush precedence:
  - Stimulus: at count=2, assert flush together with push 0x66 and m_rdy=1.
  - Response: next cycle count=0, m_valid=0; 0x66 never appears.
- Wrap, non-power-of-two:
  - Stimulus: DEPTH=3; stream 10 words 0x00..0x09 with m_rdy toggling 1,0,1,0.
  - Response: output order is exactly 0x00..0x09, and pointers wrap through 0..2 correctly.
- Stall counter:
  - Stimulus: STALL_W=2; hold full buffer with s_valid=1 for 5 cycles.
  - Response: stall_cnt saturates at 3.
  - Then stall_clr=1 on the same cycle as an increment: stall_cnt becomes 0.
- Async reset mid-operation:
  - Stimulus: at count=3, drop reset_n_in between clock edges.
  - Response: count=0, m_valid=0, s_rdy=1 without waiting for a clock edge; normal push works on the first edge after release.

Source files
------------

// File: rtl/pipe_stage_fifo.sv
// pipe_stage_fifo
//   Elastic buffer for a pipeline stage boundary (F2D, D2E, E2M, M2W).
//   It holds up to DEPTH payloads with valid/rdy handshakes on both sides.
//   It also provides a flush for branch/trap redirect, occupancy and
//   almost-full outputs, and a saturating back-pressure counter.
//
// Ports
//   clk_in       core clock, rising edge
//   reset_n_in   asynchronous active-low reset
//   s_valid      upstream payload valid
//   s_data       upstream payload
//   s_rdy        buffer accepts this cycle
//   m_valid      head entry valid
//   m_data       head entry payload, read directly from storage
//   m_rdy        downstream takes the head this cycle
//   flush        synchronous discard of all contents
//   count        current occupancy
//   almost_full  count >= DEPTH-AF_MARGIN
//   stall_cnt    saturating count of cycles with s_valid && !s_rdy
//   stall_clr    synchronous clear of stall_cnt

module pipe_stage_fifo #(
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 2,
  parameter int AF_MARGIN = 1,
  parameter int STALL_W   = 16
) (
  input  logic                           clk_in,
  input  logic                           reset_n_in,
  input  logic                           s_valid,
  input  logic [DATA_W-1:0]              s_data,
  output logic                           s_rdy,
  output logic                           m_valid,
  output logic [DATA_W-1:0]              m_data,
  input  logic                           m_rdy,
  input  logic                           flush,
  output logic [$clog2(DEPTH+1)-1:0]     count,
  output logic                           almost_full,
  output logic [STALL_W-1:0]             stall_cnt,
  input  logic                           stall_clr
);

  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_AF   = CNT_W'(DEPTH - AF_MARGIN);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

  if (DEPTH < 1 || AF_MARGIN < 0 || AF_MARGIN >= DEPTH) begin : g_bad_param
    $error("pipe_stage_fifo: illegal DEPTH/AF_MARGIN combination");
  end

  logic [DATA_W-1:0]  mem_q [DEPTH];
  logic [DATA_W-1:0]  mem_d [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [STALL_W-1:0] stall_q, stall_d;

  logic push;
  logic pop;

  // A full buffer still accepts when the head leaves in the same cycle.
  // This is the only combinational m_rdy -> s_rdy path.
  assign s_rdy       = (count_q != CNT_FULL) || m_rdy;
  assign m_valid     = (count_q != '0);
  assign m_data      = mem_q[rd_ptr_q];
  assign count       = count_q;
  assign almost_full = (count_q >= CNT_AF);
  assign stall_cnt   = stall_q;

  assign push = s_valid && s_rdy;
  assign pop  = m_valid && m_rdy;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    mem_d    = mem_q;

    if (flush) begin
      // Flush wins over any handshake in the same cycle; the data is dropped.
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = s_data;
        wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Flush does not clear the stall counter; a flush cycle is not counted.
  always_comb begin
    stall_d = stall_q;
    if (stall_clr) begin
      stall_d = '0;
    end else if (s_valid && !s_rdy && !flush && (stall_q != '1)) begin
      stall_d = stall_q + STALL_W'(1);
    end
  end

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      stall_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      stall_q  <= stall_d;
    end
  end

  // Storage has no reset; its contents are meaningless while count is 0.
  always_ff @(posedge clk_in) begin
    mem_q <= mem_d;
  end

  a_count_max : assert property (@(posedge clk_in) disable iff (!reset_n_in)
    count_q <= CNT_FULL);

  a_no_pop_empty : assert property (@(posedge clk_in) disable iff (!reset_n_in)
    !(m_rdy && m_valid && (count_q == '0)));

  a_s_data_stable : assert property (@(posedge clk_in) disable iff (!reset_n_in)
    (s_valid && !s_rdy) |=> $stable(s_data));

endmodule

// File: tb/tb_pipe_stage_fifo.sv
module tb_pipe_stage_fifo;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // Instance A: DATA_W=8, DEPTH=4, AF_MARGIN=1, STALL_W=16
  logic       a_sv, a_mr, a_fl, a_clr, a_srdy, a_mv, a_af;
  logic [7:0] a_sd, a_md;
  logic [2:0] a_cnt;
  logic [15:0] a_st;

  // Instance B: DEPTH=3 for pointer wrap
  logic       b_sv, b_mr, b_fl, b_clr, b_srdy, b_mv, b_af;
  logic [7:0] b_sd, b_md;
  logic [1:0] b_cnt;
  logic [15:0] b_st;

  // Instance C: DEPTH=4, STALL_W=2 for saturation
  logic       c_sv, c_mr, c_fl, c_clr, c_srdy, c_mv, c_af;
  logic [7:0] c_sd, c_md;
  logic [2:0] c_cnt;
  logic [1:0] c_st;

  pipe_stage_fifo #(.DATA_W(8), .DEPTH(4), .AF_MARGIN(1), .STALL_W(16)) u_a (
    .clk_in(clk), .reset_n_in(rst_n),
    .s_valid(a_sv), .s_data(a_sd), .s_rdy(a_srdy),
    .m_valid(a_mv), .m_data(a_md), .m_rdy(a_mr),
    .flush(a_fl), .count(a_cnt), .almost_full(a_af),
    .stall_cnt(a_st), .stall_clr(a_clr));

  pipe_stage_fifo #(.DATA_W(8), .DEPTH(3), .AF_MARGIN(1), .STALL_W(16)) u_b (
    .clk_in(clk), .reset_n_in(rst_n),
    .s_valid(b_sv), .s_data(b_sd), .s_rdy(b_srdy),
    .m_valid(b_mv), .m_data(b_md), .m_rdy(b_mr),
    .flush(b_fl), .count(b_cnt), .almost_full(b_af),
    .stall_cnt(b_st), .stall_clr(b_clr));

  pipe_stage_fifo #(.DATA_W(8), .DEPTH(4), .AF_MARGIN(1), .STALL_W(2)) u_c (
    .clk_in(clk), .reset_n_in(rst_n),
    .s_valid(c_sv), .s_data(c_sd), .s_rdy(c_srdy),
    .m_valid(c_mv), .m_data(c_md), .m_rdy(c_mr),
    .flush(c_fl), .count(c_cnt), .almost_full(c_af),
    .stall_cnt(c_st), .stall_clr(c_clr));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Inputs applied during one cycle, and outputs expected just before
  // the closing edge of that cycle.
  typedef struct {
    logic       sv;
    logic [7:0] sd;
    logic       mr;
    logic       fl;
    logic       clr;
    logic       e_rdy;
    logic       e_mv;
    logic [7:0] e_md;
    logic [2:0] e_cnt;
    logic       e_af;
    logic [15:0] e_st;
  } vec_t;

  vec_t vecs[$];

  logic [7:0] b_q[$];

  initial begin
    rst_n = 1'b0;
    {a_sv, a_mr, a_fl, a_clr} = '0; a_sd = '0;
    {b_sv, b_mr, b_fl, b_clr} = '0; b_sd = '0;
    {c_sv, c_mr, c_fl, c_clr} = '0; c_sd = '0;

    //                  sv  sd     mr fl clr rdy mv  md     cnt af st
    // fill and drain, including a full push/pop with 0x55
    vecs.push_back(vec_t'{1, 8'h11, 0, 0, 0, 1, 0, 8'h00, 0, 0, 0});
    vecs.push_back(vec_t'{1, 8'h22, 0, 0, 0, 1, 1, 8'h11, 1, 0, 0});
    vecs.push_back(vec_t'{1, 8'h33, 0, 0, 0, 1, 1, 8'h11, 2, 0, 0});
    vecs.push_back(vec_t'{1, 8'h44, 0, 0, 0, 1, 1, 8'h11, 3, 1, 0});
    vecs.push_back(vec_t'{1, 8'h55, 0, 0, 0, 0, 1, 8'h11, 4, 1, 0});
    vecs.push_back(vec_t'{1, 8'h55, 1, 0, 0, 1, 1, 8'h11, 4, 1, 1});
    vecs.push_back(vec_t'{0, 8'h00, 1, 0, 0, 1, 1, 8'h22, 4, 1, 1});
    vecs.push_back(vec_t'{0, 8'h00, 1, 0, 0, 1, 1, 8'h33, 3, 1, 1});
    vecs.push_back(vec_t'{0, 8'h00, 1, 0, 0, 1, 1, 8'h44, 2, 0, 1});
    vecs.push_back(vec_t'{0, 8'h00, 1, 0, 0, 1, 1, 8'h55, 1, 0, 1});
    vecs.push_back(vec_t'{0, 8'h00, 0, 0, 0, 1, 0, 8'h00, 0, 0, 1});
    // flush at count=2 with a simultaneous push and pop
    vecs.push_back(vec_t'{1, 8'h77, 0, 0, 0, 1, 0, 8'h00, 0, 0, 1});
    vecs.push_back(vec_t'{1, 8'h88, 0, 0, 0, 1, 1, 8'h77, 1, 0, 1});
    vecs.push_back(vec_t'{1, 8'h66, 1, 1, 0, 1, 1, 8'h77, 2, 0, 1});
    vecs.push_back(vec_t'{0, 8'h00, 0, 0, 0, 1, 0, 8'h00, 0, 0, 1});
    vecs.push_back(vec_t'{0, 8'h00, 1, 0, 0, 1, 0, 8'h00, 0, 0, 1});
    // stall clear, then a single word through
    vecs.push_back(vec_t'{1, 8'h99, 0, 0, 1, 1, 0, 8'h00, 0, 0, 1});
    vecs.push_back(vec_t'{0, 8'h00, 0, 0, 0, 1, 1, 8'h99, 1, 0, 0});
    vecs.push_back(vec_t'{0, 8'h00, 1, 0, 0, 1, 1, 8'h99, 1, 0, 0});
    vecs.push_back(vec_t'{0, 8'h00, 0, 0, 0, 1, 0, 8'h00, 0, 0, 0});
    // flush of a full buffer while upstream is stalled: no stall count
    vecs.push_back(vec_t'{1, 8'hA0, 0, 0, 0, 1, 0, 8'h00, 0, 0, 0});
    vecs.push_back(vec_t'{1, 8'hA1, 0, 0, 0, 1, 1, 8'hA0, 1, 0, 0});
    vecs.push_back(vec_t'{1, 8'hA2, 0, 0, 0, 1, 1, 8'hA0, 2, 0, 0});
    vecs.push_back(vec_t'{1, 8'hA3, 0, 0, 0, 1, 1, 8'hA0, 3, 1, 0});
    vecs.push_back(vec_t'{1, 8'hA4, 0, 1, 0, 0, 1, 8'hA0, 4, 1, 0});
    vecs.push_back(vec_t'{1, 8'hA4, 0, 0, 0, 1, 0, 8'h00, 0, 0, 0});
    vecs.push_back(vec_t'{0, 8'h00, 0, 0, 0, 1, 1, 8'hA4, 1, 0, 0});
    vecs.push_back(vec_t'{0, 8'h00, 1, 0, 0, 1, 1, 8'hA4, 1, 0, 0});
    vecs.push_back(vec_t'{0, 8'h00, 0, 0, 0, 1, 0, 8'h00, 0, 0, 0});

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst a_count", 32'(a_cnt), 0);
    chk("rst a_m_valid", 32'(a_mv), 0);
    chk("rst a_s_rdy", 32'(a_srdy), 1);
    chk("rst a_almost_full", 32'(a_af), 0);
    chk("rst a_stall_cnt", 32'(a_st), 0);
    chk("rst b_count", 32'(b_cnt), 0);
    chk("rst c_stall_cnt", 32'(c_st), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // table-driven run on instance A
    for (int i = 0; i < vecs.size(); i++) begin
      a_sv = vecs[i].sv; a_sd = vecs[i].sd; a_mr = vecs[i].mr;
      a_fl = vecs[i].fl; a_clr = vecs[i].clr;
      @(negedge clk);
      chk($sformatf("row%0d s_rdy", i), 32'(a_srdy), 32'(vecs[i].e_rdy));
      chk($sformatf("row%0d m_valid", i), 32'(a_mv), 32'(vecs[i].e_mv));
      chk($sformatf("row%0d count", i), 32'(a_cnt), 32'(vecs[i].e_cnt));
      chk($sformatf("row%0d almost_full", i), 32'(a_af), 32'(vecs[i].e_af));
      chk($sformatf("row%0d stall_cnt", i), 32'(a_st), 32'(vecs[i].e_st));
      if (vecs[i].e_mv)
        chk($sformatf("row%0d m_data", i), 32'(a_md), 32'(vecs[i].e_md));
      @(posedge clk); #1;
    end
    {a_sv, a_mr, a_fl, a_clr} = '0;

    // DEPTH=3 wrap: 10 words with m_rdy toggling, scoreboard on order
    begin
      int next_word = 0;
      int outs = 0;
      logic exp_rdy;
      for (int cyc = 0; cyc < 100 && outs < 10; cyc++) begin
        b_sv = (next_word < 10);
        b_sd = 8'(next_word);
        b_mr = (cyc % 2 == 0);
        @(negedge clk);
        exp_rdy = (b_q.size() != 3) || b_mr;
        chk($sformatf("wrap c%0d s_rdy", cyc), 32'(b_srdy), 32'(exp_rdy));
        chk($sformatf("wrap c%0d count", cyc), 32'(b_cnt), 32'(b_q.size()));
        chk($sformatf("wrap c%0d m_valid", cyc), 32'(b_mv), 32'(b_q.size() != 0));
        if (b_q.size() != 0 && b_mr) begin
          chk($sformatf("wrap out%0d m_data", outs), 32'(b_md), 32'(b_q.pop_front()));
          outs++;
        end
        if (b_sv && exp_rdy) begin
          b_q.push_back(8'(next_word));
          next_word++;
        end
        @(posedge clk); #1;
      end
      chk("wrap words out", 32'(outs), 10);
      b_sv = 1'b0; b_mr = 1'b0;
    end

    // STALL_W=2 saturation, then clear racing an increment
    c_mr = 1'b0;
    for (int k = 0; k < 4; k++) begin
      c_sv = 1'b1; c_sd = 8'(k);
      @(negedge clk);
      chk($sformatf("sat fill%0d count", k), 32'(c_cnt), 32'(k));
      @(posedge clk); #1;
    end
    c_sd = 8'hEE;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("sat hold%0d s_rdy", k), 32'(c_srdy), 0);
      chk($sformatf("sat hold%0d stall_cnt", k), 32'(c_st), 32'((k > 3) ? 3 : k));
      @(posedge clk); #1;
    end
    c_clr = 1'b1;
    @(negedge clk);
    chk("sat before clr", 32'(c_st), 3);
    @(posedge clk); #1;
    c_clr = 1'b0;
    @(negedge clk);
    chk("sat after clr", 32'(c_st), 0);
    @(posedge clk); #1;
    c_sv = 1'b0;

    // asynchronous reset at count=3
    a_mr = 1'b0;
    for (int k = 0; k < 3; k++) begin
      a_sv = 1'b1; a_sd = 8'hC0 + 8'(k);
      @(posedge clk); #1;
    end
    a_sv = 1'b0;
    @(negedge clk);
    chk("areset pre count", 32'(a_cnt), 3);
    #2 rst_n = 1'b0;
    #1;
    chk("areset count", 32'(a_cnt), 0);
    chk("areset m_valid", 32'(a_mv), 0);
    chk("areset s_rdy", 32'(a_srdy), 1);
    chk("areset almost_full", 32'(a_af), 0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    a_sv = 1'b1; a_sd = 8'h5A;
    @(negedge clk);
    chk("post reset count0", 32'(a_cnt), 0);
    @(posedge clk); #1;
    a_sv = 1'b0;
    @(negedge clk);
    chk("post reset count1", 32'(a_cnt), 1);
    chk("post reset m_valid", 32'(a_mv), 1);
    chk("post reset m_data", 32'(a_md), 32'h5A);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
